// File: rtl/mem_addr_arbiter_pkg.sv
// Shared definitions for the memory-address arbiter: arbitration modes and FSM states.
package mem_addr_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_addr_arbiter_rr_priority_arbiter.sv
// Combinational requester picker: fixed priority (lowest index) or round-robin
// starting at ptr. Produces a one-hot grant, the winner index and an any-request flag.
module rr_priority_arbiter
  import mem_addr_arbiter_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [N_CH-1:0]         grant,
  output logic [$clog2(N_CH)-1:0] idx,
  output logic                    valid
);

  localparam int IDW = $clog2(N_CH);
  localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

  // Walk the channels once, starting at ptr in round-robin mode, and keep the first hit.
  always_comb begin
    int start;
    int c;
    logic [N_CH-1:0] shifted;
    grant   = '0;
    idx     = '0;
    valid   = 1'b0;
    c       = 0;
    shifted = '0;
    start   = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    for (int i = 0; i < N_CH; i++) begin
      c = start + i;
      if (c >= N_CH) c = c - N_CH;
      shifted = req >> c;
      if (!valid && shifted[0]) begin
        valid = 1'b1;
        idx   = IDW'(c);
        grant = ONE << c;
      end
    end
  end

endmodule

// File: rtl/mem_addr_arbiter.sv
// Memory-address arbiter: picks a requester, truncates its address, registers it
// and runs a valid/ready handshake to memory, returning a one-cycle ack or range error.
module mem_addr_arbiter
  import mem_addr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 2,
  parameter int ARB_MODE   = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            ch_req,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_addr,
  input  logic [N_CH-1:0]            ch_we,
  output logic [N_CH-1:0]            ch_ack,
  output logic [N_CH-1:0]            ch_err,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic                       mem_we,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [$clog2(N_CH)-1:0]    grant_id
);

  localparam int IDW = $clog2(N_CH);
  localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [IDW-1:0]        rr_ptr;
  logic [N_CH-1:0]       arb_grant;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] win_addr;
  logic                  win_we;
  logic                  range_err;
  logic [IDW-1:0]        next_ptr;

  rr_priority_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req   (ch_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_any)
  );

  always_comb begin
    win_addr = '0;
    win_we   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_idx == IDW'(i)) begin
        win_addr = ch_addr[i*DATA_WIDTH +: DATA_WIDTH];
        win_we   = ch_we[i];
      end
    end
  end

  assign next_ptr = (arb_idx == IDW'(N_CH - 1)) ? '0 : arb_idx + 1'b1;

  // Upper address bits that would be dropped by truncation must be zero.
  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_range
      assign range_err = |win_addr[DATA_WIDTH-1:ADDR_WIDTH];
    end else begin : g_no_range
      assign range_err = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_valid <= 1'b0;
      ch_ack    <= '0;
      ch_err    <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            mem_addr <= win_addr[ADDR_WIDTH-1:0];
            mem_we   <= win_we;
            grant_id <= arb_idx;
            rr_ptr   <= next_ptr;
            if (range_err) begin
              ch_err <= arb_grant;
              state  <= S_DONE;
            end else begin
              mem_valid <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            ch_ack    <= ONE << grant_id;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          ch_ack <= '0;
          ch_err <= '0;
          state  <= S_IDLE;
        end
        default: begin
          ch_ack    <= '0;
          ch_err    <= '0;
          mem_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Self-checking bench: a fixed-priority 2-channel instance and a round-robin 4-channel
// instance, each compared every cycle against a transaction-level model.
module tb_mem_addr_arbiter;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic        we;
    logic [2:0]  gid;
    logic [7:0]  ack;
    logic [7:0]  err;
    logic [2:0]  ptr;
  } model_t;

  logic clk;
  logic reset;

  logic [1:0]   a_req, a_we, a_ack, a_err;
  logic [63:0]  a_addr;
  logic         a_ready, a_mwe, a_mvalid;
  logic [15:0]  a_maddr;
  logic [0:0]   a_gid;

  logic [3:0]   b_req, b_we, b_ack, b_err;
  logic [127:0] b_addr;
  logic         b_ready, b_mwe, b_mvalid;
  logic [15:0]  b_maddr;
  logic [1:0]   b_gid;

  int checks = 0;
  int errors = 0;
  model_t ma = '0;
  model_t mb = '0;

  mem_addr_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .N_CH(2), .ARB_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .ch_req(a_req), .ch_addr(a_addr), .ch_we(a_we),
    .ch_ack(a_ack), .ch_err(a_err), .mem_addr(a_maddr), .mem_we(a_mwe),
    .mem_valid(a_mvalid), .mem_ready(a_ready), .grant_id(a_gid)
  );

  mem_addr_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .N_CH(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .ch_req(b_req), .ch_addr(b_addr), .ch_we(b_we),
    .ch_ack(b_ack), .ch_err(b_err), .mem_addr(b_maddr), .mem_we(b_mwe),
    .mem_valid(b_mvalid), .mem_ready(b_ready), .grant_id(b_gid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level view: a pulse always lasts one cycle, an outstanding access waits
  // for ready, and otherwise the winning requester is taken from the arbitration rule.
  function automatic model_t model_step(model_t m, logic rst, logic [7:0] req,
                                        logic [255:0] addr, logic [7:0] we, logic ready,
                                        int n, logic rr);
    model_t r;
    int w;
    int st;
    logic [31:0] full;
    r = m;
    w = -1;
    full = '0;
    if (rst) return '0;
    if (m.ack != 0 || m.err != 0) begin
      r.ack = '0;
      r.err = '0;
    end else if (m.valid) begin
      if (ready) begin
        r.valid = 1'b0;
        r.ack   = 8'(1) << m.gid;
      end
    end else if (req != 0) begin
      st = rr ? int'(m.ptr) : 0;
      for (int i = 0; i < n; i++) begin
        if (w < 0 && req[(st + i) % n]) w = (st + i) % n;
      end
      full  = addr[w*32 +: 32];
      r.gid = 3'(w);
      r.ptr = 3'((w + 1) % n);
      r.addr = full[15:0];
      r.we   = we[w];
      if (full[31:16] != 0) r.err = 8'(1) << w;
      else                  r.valid = 1'b1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [31:0] addr0,
                               input logic [31:0] addr1, input logic [1:0] we,
                               input logic ready);
    a_req   = req;
    a_addr  = {addr1, addr0};
    a_we    = we;
    a_ready = ready;
  endtask

  // Model update on each edge, then every output of both instances compared 1 ns later.
  always @(posedge clk) begin
    ma = model_step(ma, reset, 8'(a_req), 256'(a_addr), 8'(a_we), a_ready, 2, 1'b0);
    mb = model_step(mb, reset, 8'(b_req), 256'(b_addr), 8'(b_we), b_ready, 4, 1'b1);
    #1;
    checkOutput("a_valid", 32'(a_mvalid), 32'(ma.valid));
    checkOutput("a_addr",  32'(a_maddr),  32'(ma.addr));
    checkOutput("a_we",    32'(a_mwe),    32'(ma.we));
    checkOutput("a_gid",   32'(a_gid),    32'(ma.gid[0:0]));
    checkOutput("a_ack",   32'(a_ack),    32'(ma.ack[1:0]));
    checkOutput("a_err",   32'(a_err),    32'(ma.err[1:0]));
    checkOutput("a_onehot", 32'($countones({a_ack, a_err}) <= 1), 32'd1);
    checkOutput("b_valid", 32'(b_mvalid), 32'(mb.valid));
    checkOutput("b_addr",  32'(b_maddr),  32'(mb.addr));
    checkOutput("b_we",    32'(b_mwe),    32'(mb.we));
    checkOutput("b_gid",   32'(b_gid),    32'(mb.gid[1:0]));
    checkOutput("b_ack",   32'(b_ack),    32'(mb.ack[3:0]));
    checkOutput("b_err",   32'(b_err),    32'(mb.err[3:0]));
    checkOutput("b_onehot", 32'($countones({b_ack, b_err}) <= 1), 32'd1);
  end

  initial begin
    int got;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    b_req = '0; b_addr = '0; b_we = '0; b_ready = 1'b0;

    // Reset values.
    tick();
    checkOutput("rst_valid", 32'(a_mvalid), 32'd0);
    checkOutput("rst_addr",  32'(a_maddr),  32'd0);
    checkOutput("rst_ack",   32'(a_ack),    32'd0);
    checkOutput("rst_gid",   32'(b_gid),    32'd0);
    reset = 1'b0;
    tick();

    // Fixed priority: ch0 wins, ready at cycle 2, ack at cycle 3, then ch1.
    applyStimulus(2'b11, 32'h0000_0040, 32'h0000_0080, 2'b00, 1'b0);
    tick();
    checkOutput("fix_valid1", 32'(a_mvalid), 32'd1);
    checkOutput("fix_addr1",  32'(a_maddr),  32'h0040);
    checkOutput("fix_gid1",   32'(a_gid),    32'd0);
    tick();
    a_ready = 1'b1;
    tick();
    checkOutput("fix_ack3", 32'(a_ack), 32'b01);
    checkOutput("fix_valid3", 32'(a_mvalid), 32'd0);
    a_req = 2'b10;
    tick();
    checkOutput("fix_ack4", 32'(a_ack), 32'b00);
    tick();
    checkOutput("fix_addr5", 32'(a_maddr), 32'h0080);
    checkOutput("fix_gid5",  32'(a_gid),   32'd1);
    tick();
    checkOutput("fix_ack6", 32'(a_ack), 32'b10);
    a_req = 2'b00;
    tick();

    // Wait states: ready low for several cycles, access must stay stable.
    applyStimulus(2'b10, 32'h0, 32'h0000_1234, 2'b10, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("ws_valid", 32'(a_mvalid), 32'd1);
      checkOutput("ws_addr",  32'(a_maddr),  32'h1234);
      checkOutput("ws_we",    32'(a_mwe),    32'd1);
      tick();
    end
    a_ready = 1'b1;
    tick();
    checkOutput("ws_ack", 32'(a_ack), 32'b10);
    a_req = 2'b00;
    tick();
    checkOutput("ws_ack_once", 32'(a_ack), 32'b00);

    // Out-of-range address: error pulse, no memory access.
    applyStimulus(2'b10, 32'h0, 32'h0001_0004, 2'b00, 1'b1);
    tick();
    checkOutput("err_pulse", 32'(a_err),    32'b10);
    checkOutput("err_valid", 32'(a_mvalid), 32'd0);
    a_req = 2'b00;
    tick();
    checkOutput("err_once",   32'(a_err),    32'b00);
    checkOutput("err_valid2", 32'(a_mvalid), 32'd0);

    // Request dropped right after grant still completes.
    applyStimulus(2'b01, 32'h0000_0200, 32'h0, 2'b00, 1'b0);
    tick();
    checkOutput("drop_valid", 32'(a_mvalid), 32'd1);
    a_req = 2'b00;
    tick();
    tick();
    a_ready = 1'b1;
    tick();
    checkOutput("drop_ack", 32'(a_ack), 32'b01);
    tick();

    // Reset in the middle of an access aborts it silently.
    applyStimulus(2'b01, 32'h0000_0010, 32'h0, 2'b01, 1'b0);
    tick();
    checkOutput("mid_valid", 32'(a_mvalid), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_valid", 32'(a_mvalid), 32'd0);
    checkOutput("mid_rst_addr",  32'(a_maddr),  32'd0);
    checkOutput("mid_rst_we",    32'(a_mwe),    32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mid_no_ack", 32'({a_ack, a_err}), 32'd0);
    end

    // Round-robin with all four requesters held.
    b_addr  = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    b_req   = 4'hF;
    b_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      tick();
      if (b_mvalid) begin
        checkOutput("rr_order", 32'(b_gid), 32'(rr_exp[got]));
        got++;
      end
    end
    checkOutput("rr_count", 32'(got), 32'd5);
    b_req = 4'h0;
    tick();
    tick();

    // Randomized traffic on both instances, including occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      a_req = 2'($urandom);
      b_req = 4'($urandom);
      a_we  = 2'($urandom);
      b_we  = 4'($urandom);
      for (int i = 0; i < 2; i++)
        a_addr[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 16'($urandom)};
      for (int i = 0; i < 4; i++)
        b_addr[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 16'($urandom)};
      a_ready = ($urandom_range(0, 2) != 0);
      b_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
